mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Sequencer between the MUL reservation station and the 33x33 sequential multiplier (MULT_CYCLES).
//  - Accepts one M-extension multiply per handshake and sign/zero-extends operands to 33 bits.
//  - Pulses the multiplier start, tracks latency and selects the RV32M result half.
//  - Holds the result until the CDB grants it; supports flush and back-to-back issue.
// PARAMETERS
//  MULT_CYCLES  3  multiplier latency in cycles from start to product valid (>=2)
//  P_WIDTH      6  physical register address width
//  ROB_WIDTH    5  ROB index width
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous active-high reset
//  flush          in   1          squash in-flight op (branch mispredict)
//  iss_valid      in   1          RS presents a multiply
//  iss_ready      out  1          controller can accept this cycle
//  iss_funct3     in   3          000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//  iss_rs1_data   in   32         operand a
//  iss_rs2_data   in   32         operand b
//  iss_pd_paddr   in   P_WIDTH    destination physical register
//  iss_rob_idx    in   ROB_WIDTH  ROB entry
//  mul_start      out  1          one-cycle start pulse to the multiplier
//  mul_a, mul_b   out  33 each    extended operands, stable from start until complete
//  mul_hold       out  1          tied 0 (result buffered locally)
//  mul_complete   in   1          multiplier complete flag
//  mul_product    in   66         two's-complement product
//  cdb_req        out  1          result valid, requesting the CDB
//  cdb_grant      in   1          CDB accepts the result this cycle
//  cdb_data       out  32         selected result
//  cdb_paddr      out  P_WIDTH    destination physical register
//  cdb_rob_idx    out  ROB_WIDTH  ROB entry
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all outputs 0 except iss_ready=1; operand/tag registers cleared.
//  Handshake: transfer on iss_valid&&iss_ready; capture funct3, tags and extended operands.
//  iss_ready=1 in IDLE, or in DONE when cdb_grant=1; 0 in START and BUSY.
//  Operand extension:
//   - mul_a[32] = rs1[31] when funct3 in {000,001,010}, else 0.
//   - mul_b[32] = rs2[31] when funct3 in {000,001}, else 0.
//  FSM states and transitions:
//   - IDLE: on accept -> START.
//   - START: mul_start=1 for exactly one cycle; cnt<=0 -> BUSY.
//   - BUSY: cnt increments each cycle. When cnt>=MULT_CYCLES-1 and mul_complete=1:
//     latch the selected result into cdb_data -> DONE. A mul_complete already high
//     from a prior op while cnt<MULT_CYCLES-1 is ignored.
//   - DONE: cdb_req=1; cdb_data/paddr/rob_idx stable while cdb_grant=0.
//     On grant: with a new accept -> START, else -> IDLE.
//  Result select: funct3=000 -> product[31:0]; 001/010/011 -> product[63:32].
//  Latency: accept edge T -> mul_start high in cycle T+1.
//   - cdb_req rises MULT_CYCLES+1 cycles after the start cycle, given mul_complete on time.
//  Throughput: one op in flight. Back-to-back grant+accept costs no idle cycle.
//  flush (priority over all else except rst):
//   - Next state IDLE; cnt, cdb_req and mul_start cleared.
//   - An accept in the flush cycle is dropped; iss_ready is forced 0 that cycle.
//   - The multiplier's in-flight result is discarded. A later start restarts it.
//  Reset mid-operation: same as flush plus all registers cleared; no cdb_req is emitted.
//  funct3[2]=1 is never issued here; the bench asserts on it.
// TESTING
//  1. MUL 7*6, MULT_CYCLES=3, grant tied 1 -> cdb_data=0x0000002A.
//     cdb_req 4 cycles after mul_start; correct paddr/rob_idx.
//  2. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE.
//  3. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF. MULH 0x80000000*0x80000000 -> 0x40000000.
//  4. Grant low 5 cycles in DONE -> cdb_req and data held stable, iss_ready=0.
//     Grant with iss_valid in the same cycle -> mul_start the next cycle.
//  5. Flush in BUSY cycle 1 -> IDLE next cycle, no cdb_req.
//     Next op issued immediately returns its own correct result, not the stale product.
//  6. rst asserted in DONE -> all outputs reset next cycle, iss_ready=1.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue sequencer between the MUL reservation station and a sequential multiplier
//
// Accepts one RV32M multiply per handshake and sign/zero-extends both operands to
// 33 bits. It then pulses the multiplier start, waits out the multiplier latency and
// selects the low or high result half. The result is held for the CDB until granted.
// Only one operation is in flight at a time. A CDB grant and a new issue can be taken
// in the same cycle, so back-to-back operations cost no idle cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             squash the in-flight op; also drops any accept that cycle
//   iss_*             issue handshake from the reservation station (valid/ready, funct3, operands, tags)
//   mul_start         one-cycle start pulse to the multiplier
//   mul_a, mul_b      33-bit extended operands, held from start until complete
//   mul_hold          always 0; the result is buffered here instead
//   mul_complete      multiplier done flag (may stay high from a previous op)
//   mul_product       66-bit two's-complement product
//   cdb_*             result broadcast request/grant, data and destination tags

module mul_issue_ctrl #(
    parameter int MULT_CYCLES = 3,
    parameter int P_WIDTH     = 6,
    parameter int ROB_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [2:0]           iss_funct3,
    input  logic [31:0]          iss_rs1_data,
    input  logic [31:0]          iss_rs2_data,
    input  logic [P_WIDTH-1:0]   iss_pd_paddr,
    input  logic [ROB_WIDTH-1:0] iss_rob_idx,

    output logic                 mul_start,
    output logic [32:0]          mul_a,
    output logic [32:0]          mul_b,
    output logic                 mul_hold,
    input  logic                 mul_complete,
    input  logic [65:0]          mul_product,

    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic [31:0]          cdb_data,
    output logic [P_WIDTH-1:0]   cdb_paddr,
    output logic [ROB_WIDTH-1:0] cdb_rob_idx
);

    // The counter only has to reach MULT_CYCLES-1; it saturates there so that a
    // multiplier that is late to complete cannot wrap it back below the threshold.
    localparam int             CW       = $clog2(MULT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MULT_CYCLES - 1);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             funct3_q;
    logic [32:0]            mul_a_q;
    logic [32:0]            mul_b_q;
    logic [P_WIDTH-1:0]     paddr_q;
    logic [ROB_WIDTH-1:0]   rob_q;
    logic [31:0]            cdb_data_q;

    logic                   accept;
    logic                   a_signed;
    logic                   b_signed;
    logic                   result_ready;
    logic [31:0]            result_sel;

    // The top two product bits only matter for the 33x33 corner cases that RV32M
    // never asks for; they are not part of any selected result.
    logic [1:0]             unused_product_msbs;
    assign unused_product_msbs = mul_product[65:64];

    // A flush wins over any handshake, so ready drops for that cycle.
    always_comb begin
        iss_ready = 1'b0;
        if (!flush) begin
            if (state_q == ST_IDLE) begin
                iss_ready = 1'b1;
            end else if (state_q == ST_DONE && cdb_grant) begin
                iss_ready = 1'b1;
            end
        end
    end

    assign accept = iss_valid && iss_ready;

    // rs1 is signed for MUL/MULH/MULHSU and rs2 for MUL/MULH. MUL only keeps the
    // low word, so its signedness does not change the result.
    assign a_signed = (iss_funct3 == F3_MUL) || (iss_funct3 == F3_MULH) ||
                      (iss_funct3 == F3_MULHSU);
    assign b_signed = (iss_funct3 == F3_MUL) || (iss_funct3 == F3_MULH);

    // mul_complete can still be high from an earlier (possibly flushed) operation.
    // It is trusted only once the counter shows this op has had its full latency.
    assign result_ready = (cnt_q >= CNT_LAST) && mul_complete;

    assign result_sel = (funct3_q == F3_MUL) ? mul_product[31:0] : mul_product[63:32];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (result_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cdb_grant) begin
                    state_d = accept ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            if (cnt_q < CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Operands and tags are captured at the handshake. They stay put until the next
    // accept, so mul_a/mul_b are stable for the whole multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            paddr_q  <= '0;
            rob_q    <= '0;
        end else if (accept) begin
            funct3_q <= iss_funct3;
            mul_a_q  <= {a_signed & iss_rs1_data[31], iss_rs1_data};
            mul_b_q  <= {b_signed & iss_rs2_data[31], iss_rs2_data};
            paddr_q  <= iss_pd_paddr;
            rob_q    <= iss_rob_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_data_q <= '0;
        end else if (!flush && state_q == ST_BUSY && result_ready) begin
            cdb_data_q <= result_sel;
        end
    end

    assign mul_start   = (state_q == ST_START);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_hold    = 1'b0;

    assign cdb_req     = (state_q == ST_DONE);
    assign cdb_data    = cdb_data_q;
    assign cdb_paddr   = paddr_q;
    assign cdb_rob_idx = rob_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl with a behavioural multiplier and RV32M reference
module tb_mul_issue_ctrl;

    localparam int MC = 3;
    localparam int PW = 6;
    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          iss_valid;
    logic          iss_ready;
    logic [2:0]    iss_funct3;
    logic [31:0]   iss_rs1_data;
    logic [31:0]   iss_rs2_data;
    logic [PW-1:0] iss_pd_paddr;
    logic [RW-1:0] iss_rob_idx;
    logic          mul_start;
    logic [32:0]   mul_a;
    logic [32:0]   mul_b;
    logic          mul_hold;
    logic          mul_complete;
    logic [65:0]   mul_product;
    logic          cdb_req;
    logic          cdb_grant;
    logic [31:0]   cdb_data;
    logic [PW-1:0] cdb_paddr;
    logic [RW-1:0] cdb_rob_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    logic          grant_tied;
    logic [31:0]   exp_data;
    logic [PW-1:0] exp_pd;
    logic [RW-1:0] exp_rob;

    mul_issue_ctrl #(.MULT_CYCLES(MC), .P_WIDTH(PW), .ROB_WIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_funct3   (iss_funct3),
        .iss_rs1_data (iss_rs1_data),
        .iss_rs2_data (iss_rs2_data),
        .iss_pd_paddr (iss_pd_paddr),
        .iss_rob_idx  (iss_rob_idx),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_hold     (mul_hold),
        .mul_complete (mul_complete),
        .mul_product  (mul_product),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_data     (cdb_data),
        .cdb_paddr    (cdb_paddr),
        .cdb_rob_idx  (cdb_rob_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential multiplier: complete rises MC cycles after start and is left high
    // afterwards, so the next op always sees a stale complete at first.
    logic [32:0] m_a;
    logic [32:0] m_b;
    int          m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt        <= 0;
            mul_complete <= 1'b0;
            mul_product  <= '0;
            m_a          <= '0;
            m_b          <= '0;
        end else if (mul_start) begin
            m_a   <= mul_a;
            m_b   <= mul_b;
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == MC - 1) begin
                mul_complete <= 1'b1;
                mul_product  <= {{33{m_a[32]}}, m_a} * {{33{m_b[32]}}, m_b};
                m_cnt        <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'b001:  p = 64'(sa * sb);
            3'b010:  p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iss_ready"}, 66'(iss_ready), 66'd1);
        chk({tag, "_mul_start"}, 66'(mul_start), 66'd0);
        chk({tag, "_mul_a"},     66'(mul_a), 66'd0);
        chk({tag, "_mul_b"},     66'(mul_b), 66'd0);
        chk({tag, "_mul_hold"},  66'(mul_hold), 66'd0);
        chk({tag, "_cdb_req"},   66'(cdb_req), 66'd0);
        chk({tag, "_cdb_data"},  66'(cdb_data), 66'd0);
        chk({tag, "_cdb_paddr"}, 66'(cdb_paddr), 66'd0);
        chk({tag, "_cdb_rob"},   66'(cdb_rob_idx), 66'd0);
    endtask

    // Presents an op and expects it to be accepted this cycle; ends in the start cycle.
    task automatic accept_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [PW-1:0] pd, input logic [RW-1:0] rob,
                             input logic [31:0] exp);
        logic [32:0] ea;
        logic [32:0] eb;
        ea = {(f != 3'b011) && a[31], a};
        eb = {(f == 3'b000 || f == 3'b001) && b[31], b};
        iss_valid    = 1'b1;
        iss_funct3   = f;
        iss_rs1_data = a;
        iss_rs2_data = b;
        iss_pd_paddr = pd;
        iss_rob_idx  = rob;
        exp_data     = exp;
        exp_pd       = pd;
        exp_rob      = rob;
        #1;
        chk("accept_ready", 66'(iss_ready), 66'd1);
        tick();
        iss_valid    = 1'b0;
        cdb_grant    = grant_tied;
        iss_rs1_data = $urandom;
        iss_rs2_data = $urandom;
        iss_pd_paddr = PW'($urandom);
        iss_rob_idx  = RW'($urandom);
        #1;
        chk("start_pulse", 66'(mul_start), 66'd1);
        chk("start_no_req", 66'(cdb_req), 66'd0);
        chk("start_not_ready", 66'(iss_ready), 66'd0);
        chk("mul_a_ext", 66'(mul_a), 66'(ea));
        chk("mul_b_ext", 66'(mul_b), 66'(eb));
    endtask

    // Counts cycles from the start cycle until cdb_req, then checks the result.
    task automatic wait_result();
        int n;
        n = 0;
        do begin
            tick();
            #1;
            n++;
            if (n == 1) chk("start_one_cycle", 66'(mul_start), 66'd0);
        end while (!cdb_req && n < 20);
        chk("req_latency", 66'(n), 66'(MC + 1));
        chk("cdb_data", 66'(cdb_data), 66'(exp_data));
        chk("cdb_paddr", 66'(cdb_paddr), 66'(exp_pd));
        chk("cdb_rob", 66'(cdb_rob_idx), 66'(exp_rob));
    endtask

    task automatic grant_result();
        cdb_grant = 1'b1;
        #1;
        chk("grant_ready", 66'(iss_ready), 66'd1);
        tick();
        cdb_grant = grant_tied;
        #1;
        chk("post_grant_req", 66'(cdb_req), 66'd0);
        chk("post_grant_idle_ready", 66'(iss_ready), 66'd1);
        chk("post_grant_no_start", 66'(mul_start), 66'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    f;
        logic [31:0]   a;
        logic [31:0]   b;
        logic          pending;

        rst          = 1'b1;
        flush        = 1'b0;
        iss_valid    = 1'b0;
        iss_funct3   = '0;
        iss_rs1_data = '0;
        iss_rs2_data = '0;
        iss_pd_paddr = '0;
        iss_rob_idx  = '0;
        cdb_grant    = 1'b0;
        grant_tied   = 1'b0;
        repeat (3) tick();
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // MUL 7*6 with grant tied high.
        grant_tied = 1'b1;
        cdb_grant  = 1'b1;
        accept_op(3'b000, 32'd7, 32'd6, 6'd17, 5'd9, 32'h0000_002A);
        wait_result();
        grant_result();
        grant_tied = 1'b0;
        cdb_grant  = 1'b0;

        // High-half variants and sign corners.
        accept_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 5'd1, 32'h0000_0000);
        wait_result();
        grant_result();
        accept_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 5'd2, 32'hFFFF_FFFE);
        wait_result();
        grant_result();
        accept_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 6'd3, 5'd3, 32'hFFFF_FFFF);
        wait_result();
        grant_result();
        accept_op(3'b001, 32'h8000_0000, 32'h8000_0000, 6'd4, 5'd4, 32'h4000_0000);
        wait_result();

        // Grant withheld for 5 cycles, then grant and a new issue in the same cycle.
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 66'(cdb_req), 66'd1);
            chk("hold_data", 66'(cdb_data), 66'(32'h4000_0000));
            chk("hold_paddr", 66'(cdb_paddr), 66'd4);
            chk("hold_not_ready", 66'(iss_ready), 66'd0);
            tick();
            #1;
        end
        cdb_grant = 1'b1;
        accept_op(3'b000, 32'hFFFF_FFFD, 32'd5, 6'd5, 5'd5, 32'hFFFF_FFF1);
        wait_result();
        grant_result();

        // Flush in the first BUSY cycle; an issue in the flush cycle is dropped.
        accept_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 6'd6, 5'd6, 32'h0);
        tick();
        flush        = 1'b1;
        iss_valid    = 1'b1;
        iss_funct3   = 3'b000;
        iss_rs1_data = 32'd3;
        iss_rs2_data = 32'd3;
        #1;
        chk("flush_busy_not_ready", 66'(iss_ready), 66'd0);
        tick();
        flush     = 1'b0;
        iss_valid = 1'b0;
        #1;
        chk("flush_to_idle_ready", 66'(iss_ready), 66'd1);
        chk("flush_no_start", 66'(mul_start), 66'd0);
        chk("flush_no_req", 66'(cdb_req), 66'd0);
        accept_op(3'b000, 32'd11, 32'd13, 6'd7, 5'd7, 32'd143);
        wait_result();

        // Flush in DONE with grant and issue: ready forced low, issue dropped.
        flush        = 1'b1;
        cdb_grant    = 1'b1;
        iss_valid    = 1'b1;
        iss_funct3   = 3'b000;
        iss_rs1_data = 32'd2;
        iss_rs2_data = 32'd2;
        #1;
        chk("flush_done_ready_forced", 66'(iss_ready), 66'd0);
        tick();
        flush     = 1'b0;
        cdb_grant = 1'b0;
        iss_valid = 1'b0;
        #1;
        chk("flush_done_no_start", 66'(mul_start), 66'd0);
        chk("flush_done_no_req", 66'(cdb_req), 66'd0);
        chk("flush_done_idle_ready", 66'(iss_ready), 66'd1);

        // Reset while a result waits in DONE.
        accept_op(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd8, 5'd8, 32'h3FFF_FFFF);
        wait_result();
        rst = 1'b1;
        tick();
        #1;
        chk_reset_outputs("rst_done");
        rst = 1'b0;
        tick();

        // Randomised ops against the reference, with random grant delays and b2b issue.
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            if (pending) begin
                repeat ($urandom_range(0, 2)) begin
                    chk("rand_hold_req", 66'(cdb_req), 66'd1);
                    chk("rand_hold_data", 66'(cdb_data), 66'(exp_data));
                    tick();
                    #1;
                end
                cdb_grant = 1'b1;
            end
            accept_op(f, a, b, PW'($urandom), RW'($urandom), ref_mul(f, a, b));
            wait_result();
            pending = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                grant_result();
                pending = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        if (pending) grant_result();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
